seg_scan_timer: RTL and testbench
=================================

Name: seg_scan_timer

Overview:
Parametrised digit-scan timer for the multiplexed seven-segment display. A free-running prescaler advances a digit index modulo NUM_DIGITS and drives a one-hot anode vector directly. Adds enable, synchronous clear, per-digit blanking, an anti-ghosting dead time at the start of each digit slot, and a one-cycle tick pulse for the segment-data mux and the decoder. With the defaults, digit changes every 2^17 clocks, which is the same cadence as the current 4-digit scan.

Parameters:
PRESCALE_W, 17, prescaler width; one digit slot lasts 2^PRESCALE_W clocks.
NUM_DIGITS, 4, number of digits scanned; must be at least 2, and need not be a power of 2.
DIGIT_W, 2, width of digit_idx; must be at least clog2(NUM_DIGITS).
DEAD_CYCLES, 16, clocks at the start of each slot with all anodes inactive; must be less than 2^PRESCALE_W.
ANODE_ACTIVE_LOW, 1, 1 means an active anode is driven 0 and an inactive anode 1; 0 inverts this.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous, active-low reset.
en  in  1  scan enable; when low, counting holds and the display is dark.
clr  in  1  synchronous restart to digit 0, slot start.
blank_mask  in  NUM_DIGITS  bit i = 1 keeps anode i inactive for its whole slot.
anode  out  NUM_DIGITS  one-hot anode drive, registered.
digit_idx  out  DIGIT_W  current digit, registered; selects segment data.
tick  out  1  one-cycle pulse in the first cycle of each new digit slot.

Behaviour:
- Reset (rst_n = 0, asynchronous):
  - presc = 0, digit_idx = 0, tick = 0.
  - anode = all inactive (all 1 when ANODE_ACTIVE_LOW = 1).
  - Reset deassertion is used synchronously; the counting sequence starts from presc = 0.
- Priority per rising edge: clr, then en, then hold.
- clr = 1:
  - presc = 0, digit_idx = 0, tick = 0, anode = all inactive.
  - Overrides en.
- en = 1, clr = 0:
  - presc < max (all ones): presc increments by 1, digit_idx holds, tick = 0.
  - presc = max: presc wraps to 0 and tick = 1.
  - On wrap, digit_idx goes to digit_idx + 1, except digit_idx = NUM_DIGITS-1, which goes to 0.
  - digit_idx never takes values at or above NUM_DIGITS.
- en = 0, clr = 0:
  - presc and digit_idx hold.
  - tick = 0, anode = all inactive.
  - On re-enable, counting resumes from the held presc value; there is no slot restart.
- Anode decode: anode is registered from the next-state presc and digit_idx, so it is aligned with digit_idx with zero cycle lag.
  - Digit i is active only if all of these hold:
    - en = 1 and clr = 0;
    - next digit_idx = i;
    - next presc >= DEAD_CYCLES;
    - blank_mask[i] = 0.
  - Otherwise all anode bits are inactive.
  - At most one anode bit is active in any cycle.
  - DEAD_CYCLES = 0 disables the dead time.
- blank_mask is sampled every cycle with no latching. A change mid-slot takes effect on the next edge.
- Timing of a slot, with no clr or en change:
  - tick is high exactly once per 2^PRESCALE_W clocks.
  - Anode i is active for 2^PRESCALE_W - DEAD_CYCLES consecutive clocks.
  - A full frame is NUM_DIGITS * 2^PRESCALE_W clocks.
- Simultaneous events:
  - clr together with the presc-max edge: clr wins, and there is no tick.
  - en falling on the presc-max edge: no advance.
- Reset asserted mid-slot forces all outputs to their reset values immediately, without waiting for a clock edge.

Decomposition:
- Shared package seg_pkg:
  - clog2 constant function;
  - ANODE_ON/ANODE_OFF polarity constants derived from ANODE_ACTIVE_LOW;
  - default scan constants (PRESCALE_W = 17, NUM_DIGITS = 4).
- One sub-module, scan_prescaler:
  - PRESCALE_W-bit counter with en, clr and async rst_n;
  - outputs presc_next and a wrap strobe.
- The top level holds the modulo digit counter, the anode decode/mask register and the tick register.

Test Plan:
Bench configuration: PRESCALE_W = 4, NUM_DIGITS = 3, DIGIT_W = 2, DEAD_CYCLES = 2, active-low.
1. Reset then en = 1, blank_mask = 000:
   - after reset, anode = 111, digit_idx = 0, tick = 0;
   - tick pulses once every 16 clocks;
   - digit_idx follows 0, 1, 2, 0;
   - anode 110 is held for 14 clocks after 2 dead clocks of 111, then 101, then 011.
2. Non-power-of-2 wrap: run 3 frames (144 clocks) -> digit_idx never equals 3; exactly 9 ticks.
3. blank_mask = 010 -> anode stays 111 throughout the digit-1 slot; tick and the digit_idx sequence are unchanged.
4. en dropped for 5 clocks at presc = 7 in slot 1:
   - anode = 111 and tick = 0 for those 5 clocks;
   - on re-enable, presc resumes at 8 and slot 1 completes 9 clocks later.
5. clr pulsed on the same edge as presc = 15 in slot 2 -> no tick; digit_idx = 0, presc = 0, anode = 111 for 2 dead clocks, then 110.
6. rst_n asserted mid-slot between clock edges:
   - anode = 111, digit_idx = 0 and tick = 0 immediately, before the next clk edge;
   - after release, the first tick occurs 16 clocks after the first enabled edge.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants and helpers for the seven-segment digit scanner.
package seg_pkg;

    localparam int PRESCALE_W_DEF  = 17;
    localparam int NUM_DIGITS_DEF  = 4;
    localparam int DIGIT_W_DEF     = 2;
    localparam int DEAD_CYCLES_DEF = 16;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    // Anode drive level for an active digit, given the board polarity.
    function automatic logic anode_on_lvl(input bit active_low);
        return active_low ? 1'b0 : 1'b1;
    endfunction

    function automatic logic anode_off_lvl(input bit active_low);
        return active_low ? 1'b1 : 1'b0;
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Free-running slot prescaler: exposes its next state so the top can decode
// anodes with zero lag, plus a strobe on the all-ones -> 0 wrap.
module scan_prescaler
    import seg_pkg::*;
#(
    parameter int PRESCALE_W = PRESCALE_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  clr,
    output logic [PRESCALE_W-1:0] presc_next,
    output logic                  wrap
);

    logic [PRESCALE_W-1:0] presc;

    always_comb begin
        presc_next = presc;
        if (clr)
            presc_next = '0;
        else if (en)
            presc_next = presc + PRESCALE_W'(1);
    end

    // clr outranks the wrap, so a clear on the last slot cycle gives no tick.
    assign wrap = en && !clr && (presc == '1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            presc <= '0;
        else
            presc <= presc_next;
    end

endmodule

// File: rtl/seg_scan_timer.sv
// Multiplexed seven-segment digit scanner: modulo digit counter, dead-time and
// blanking anode decode, and a one-cycle tick at the start of every slot.
module seg_scan_timer
    import seg_pkg::*;
#(
    parameter int PRESCALE_W       = PRESCALE_W_DEF,
    parameter int NUM_DIGITS       = NUM_DIGITS_DEF,
    parameter int DIGIT_W          = DIGIT_W_DEF,
    parameter int DEAD_CYCLES      = DEAD_CYCLES_DEF,
    parameter bit ANODE_ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  clr,
    input  logic [NUM_DIGITS-1:0] blank_mask,
    output logic [NUM_DIGITS-1:0] anode,
    output logic [DIGIT_W-1:0]    digit_idx,
    output logic                  tick
);

    localparam logic                  ANODE_ON  = anode_on_lvl(ANODE_ACTIVE_LOW);
    localparam logic                  ANODE_OFF = anode_off_lvl(ANODE_ACTIVE_LOW);
    localparam logic [DIGIT_W-1:0]    LAST_DIG  = DIGIT_W'(NUM_DIGITS - 1);
    localparam logic [PRESCALE_W-1:0] DEAD      = PRESCALE_W'(DEAD_CYCLES);

    logic [PRESCALE_W-1:0] presc_next;
    logic                  wrap;
    logic [DIGIT_W-1:0]    digit_next;
    logic                  lit;
    logic [NUM_DIGITS-1:0] anode_next;

    scan_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_presc (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .clr        (clr),
        .presc_next (presc_next),
        .wrap       (wrap)
    );

    // Explicit compare against the last digit so non-power-of-2 counts wrap cleanly.
    always_comb begin
        digit_next = digit_idx;
        if (clr)
            digit_next = '0;
        else if (wrap)
            digit_next = (digit_idx == LAST_DIG) ? '0 : digit_idx + DIGIT_W'(1);
    end

    assign lit = en && !clr && (presc_next >= DEAD);

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_anode
        assign anode_next[i] = (lit && (digit_next == DIGIT_W'(i)) && !blank_mask[i])
                             ? ANODE_ON : ANODE_OFF;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_idx <= '0;
            tick      <= 1'b0;
            anode     <= {NUM_DIGITS{ANODE_OFF}};
        end else begin
            digit_idx <= digit_next;
            tick      <= wrap;
            anode     <= anode_next;
        end
    end

endmodule

// File: tb/tb_seg_scan_timer.sv
// Directed bench for seg_scan_timer with a slot/digit model checked every cycle.
module tb_seg_scan_timer;

    localparam int PW   = 4;
    localparam int ND   = 3;
    localparam int DW   = 2;
    localparam int DEAD = 2;
    localparam int SLOT = 1 << PW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          clr = 1'b0;
    logic [ND-1:0] blank_mask = '0;
    logic [ND-1:0] anode;
    logic [DW-1:0] digit_idx;
    logic          tick;

    int vectors = 0;
    int errors  = 0;

    // Model state: position within the slot and which digit owns the slot.
    int            m_pos = 0;
    int            m_dig = 0;
    logic          m_tick = 1'b0;
    logic [ND-1:0] m_anode = 3'b111;

    always #5 clk = ~clk;

    seg_scan_timer #(
        .PRESCALE_W       (PW),
        .NUM_DIGITS       (ND),
        .DIGIT_W          (DW),
        .DEAD_CYCLES      (DEAD),
        .ANODE_ACTIVE_LOW (1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .clr        (clr),
        .blank_mask (blank_mask),
        .anode      (anode),
        .digit_idx  (digit_idx),
        .tick       (tick)
    );

    function automatic logic [ND-1:0] exp_anode(input int pos, input int dig,
                                                input logic [ND-1:0] mask);
        logic [ND-1:0] a;
        a = '1;
        if (pos >= DEAD && !mask[dig]) a[dig] = 1'b0;
        return a;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pos <= 0; m_dig <= 0; m_tick <= 1'b0; m_anode <= '1;
        end else if (clr) begin
            m_pos <= 0; m_dig <= 0; m_tick <= 1'b0; m_anode <= '1;
        end else if (en) begin
            m_pos   <= (m_pos + 1) % SLOT;
            m_dig   <= (m_pos == SLOT - 1) ? (m_dig + 1) % ND : m_dig;
            m_tick  <= (m_pos == SLOT - 1);
            m_anode <= exp_anode((m_pos + 1) % SLOT,
                                 (m_pos == SLOT - 1) ? (m_dig + 1) % ND : m_dig,
                                 blank_mask);
        end else begin
            m_tick  <= 1'b0;
            m_anode <= '1;
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // One clock, sampled on the falling edge, then compared with the model.
    task automatic step();
        @(negedge clk);
        chk("model anode", int'(anode), int'(m_anode));
        chk("model digit_idx", int'(digit_idx), m_dig);
        chk("model tick", int'(tick), int'(m_tick));
    endtask

    initial begin
        int ticks;
        int bad;
        int first;

        // 1. reset, then basic scan
        repeat (2) @(negedge clk);
        chk("reset anode", int'(anode), 7);
        chk("reset digit_idx", int'(digit_idx), 0);
        chk("reset tick", int'(tick), 0);
        rst_n = 1'b1;
        step();
        en = 1'b1;
        step();             chk("s0 dead", int'(anode), 7);
        step();             chk("s0 lit", int'(anode), 6);
        repeat (13) step();
        chk("s0 last anode", int'(anode), 6);
        chk("s0 last digit", int'(digit_idx), 0);
        chk("s0 last tick", int'(tick), 0);
        step();
        chk("s1 tick", int'(tick), 1);
        chk("s1 digit", int'(digit_idx), 1);
        chk("s1 dead", int'(anode), 7);
        repeat (2) step();
        chk("s1 lit", int'(anode), 5);
        chk("s1 tick low", int'(tick), 0);
        repeat (14) step();
        chk("s2 tick", int'(tick), 1);
        chk("s2 digit", int'(digit_idx), 2);
        repeat (2) step();
        chk("s2 lit", int'(anode), 3);
        repeat (14) step();
        chk("frame wrap tick", int'(tick), 1);
        chk("frame wrap digit", int'(digit_idx), 0);

        // 2. three full frames
        ticks = 0; bad = 0;
        repeat (3 * ND * SLOT) begin
            step();
            if (tick) ticks++;
            if (int'(digit_idx) >= ND) bad++;
        end
        chk("3 frames ticks", ticks, 9);
        chk("3 frames digit range", bad, 0);

        // 3. blank digit 1 for one frame
        blank_mask = 3'b010;
        ticks = 0; bad = 0;
        repeat (ND * SLOT) begin
            step();
            if (tick) ticks++;
            if (digit_idx == 2'd1 && anode != 3'b111) bad++;
        end
        chk("blank d1 dark", bad, 0);
        chk("blank ticks", ticks, 3);
        blank_mask = 3'b000;

        // 4. pause at presc 7 in slot 1
        repeat (SLOT + 7) step();
        chk("pause digit", int'(digit_idx), 1);
        en = 1'b0;
        bad = 0;
        repeat (5) begin
            step();
            if (anode != 3'b111 || tick) bad++;
        end
        chk("pause dark", bad, 0);
        chk("pause hold digit", int'(digit_idx), 1);
        en = 1'b1;
        step();             chk("resume lit", int'(anode), 5);
        repeat (7) step();
        chk("resume no tick", int'(tick), 0);
        chk("resume digit", int'(digit_idx), 1);
        step();
        chk("resume tick", int'(tick), 1);
        chk("resume next digit", int'(digit_idx), 2);

        // 5. clr on the presc-max edge of slot 2
        repeat (SLOT - 1) step();
        clr = 1'b1;
        step();
        chk("clr no tick", int'(tick), 0);
        chk("clr digit", int'(digit_idx), 0);
        chk("clr anode", int'(anode), 7);
        clr = 1'b0;
        step();             chk("clr dead", int'(anode), 7);
        step();             chk("clr lit", int'(anode), 6);

        // 6. asynchronous reset mid-slot
        repeat (20) step();
        chk("pre-reset digit", int'(digit_idx), 1);
        chk("pre-reset anode", int'(anode), 5);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset anode", int'(anode), 7);
        chk("async reset digit", int'(digit_idx), 0);
        chk("async reset tick", int'(tick), 0);
        repeat (2) step();
        rst_n = 1'b1;
        first = 0;
        for (int k = 1; k <= 40 && first == 0; k++) begin
            step();
            if (tick) first = k;
        end
        chk("first tick after reset", first, SLOT);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
